// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Result-source and CDB broadcast bundle for cdb_arbiter.
//               master = producers/consumers side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
  parameter int NUM_SRC  = 3,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 5
);
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [NUM_SRC*ROB_ID_W-1:0] src_rob_id;
  logic [NUM_SRC-1:0]          src_ready;
  logic                        cdb_valid;
  logic [DATA_W-1:0]           cdb_data;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [1:0]                  cdb_src;

  modport master (
    output src_valid, src_data, src_rob_id,
    input  src_ready, cdb_valid, cdb_data, cdb_rob_id, cdb_src
  );

  modport slave (
    input  src_valid, src_data, src_rob_id,
    output src_ready, cdb_valid, cdb_data, cdb_rob_id, cdb_src
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common-data-bus arbiter. One holding slot per result source
//               (0 = ALU, 1 = LSB, 2 = MUL/DIV); one full slot is granted per
//               cycle onto a registered CDB broadcast. A ROB flush discards
//               every pending result.
//               Build option CDB_FIXED_PRIO_EN: lowest-index full slot always
//               wins (no round-robin pointer). Default: round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_SRC  = 3,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 5
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  input  wire logic     rdy,
  input  wire logic     flush,
  cdb_arbiter_if.slave  bus
);

  logic [NUM_SRC-1:0]  r_slot_valid;
  logic [DATA_W-1:0]   r_slot_data [NUM_SRC];
  logic [ROB_ID_W-1:0] r_slot_id   [NUM_SRC];

  logic                r_cdb_valid;
  logic [DATA_W-1:0]   r_cdb_data;
  logic [ROB_ID_W-1:0] r_cdb_rob_id;
  logic [1:0]          r_cdb_src;

  logic [DATA_W-1:0]   w_src_data [NUM_SRC];
  logic [ROB_ID_W-1:0] w_src_id   [NUM_SRC];
  logic [NUM_SRC-1:0]  w_grant;
  logic [NUM_SRC-1:0]  w_ready;
  logic [NUM_SRC-1:0]  w_accept;
  logic                w_any;
  logic [1:0]          w_gnt_idx;

`ifndef CDB_FIXED_PRIO_EN
  localparam logic [2:0] c_num_src = 3'(NUM_SRC);
  logic [1:0] r_rr_ptr;
  logic [1:0] w_rr_next;
`endif

  // Split the packed per-source buses into per-slot views.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign w_src_data[i] = bus.src_data[i*DATA_W +: DATA_W];
    assign w_src_id[i]   = bus.src_rob_id[i*ROB_ID_W +: ROB_ID_W];
  end

  // Pick the first full slot, starting at the round-robin pointer (or at 0).
  always_comb begin
    logic [2:0] scan;
    w_grant   = '0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    scan      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_FIXED_PRIO_EN
      scan = 3'(k);
`else
      scan = {1'b0, r_rr_ptr} + 3'(k);
      if (scan >= c_num_src) scan = scan - c_num_src;
`endif
      if (!w_any && r_slot_valid[scan[1:0]]) begin
        w_any               = 1'b1;
        w_grant[scan[1:0]]  = 1'b1;
        w_gnt_idx           = scan[1:0];
      end
    end
  end

`ifndef CDB_FIXED_PRIO_EN
  assign w_rr_next = ({1'b0, w_gnt_idx} == c_num_src - 3'd1) ? 2'd0 : w_gnt_idx + 2'd1;
`endif

  // A slot being drained this cycle can be refilled on the same edge.
  assign w_ready  = {NUM_SRC{rdy & ~flush}} & (~r_slot_valid | w_grant);
  assign w_accept = bus.src_valid & w_ready;

  // Holding slots: load on accept, release on grant, drop everything on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_valid <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_slot_data[i] <= '0;
        r_slot_id[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush) begin
          r_slot_valid[i] <= 1'b0;
        end else if (w_accept[i]) begin
          r_slot_valid[i] <= 1'b1;
          r_slot_data[i]  <= w_src_data[i];
          r_slot_id[i]    <= w_src_id[i];
        end else if (w_grant[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast; payload holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_data   <= '0;
      r_cdb_rob_id <= '0;
      r_cdb_src    <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_cdb_valid <= 1'b0;
      end else if (w_any) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_data   <= r_slot_data[w_gnt_idx];
        r_cdb_rob_id <= r_slot_id[w_gnt_idx];
        r_cdb_src    <= w_gnt_idx;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

`ifndef CDB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the last granted source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_rr_ptr <= '0;
      end else if (w_any) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end
`endif

  assign bus.src_ready  = w_ready;
  assign bus.cdb_valid  = r_cdb_valid;
  assign bus.cdb_data   = r_cdb_data;
  assign bus.cdb_rob_id = r_cdb_rob_id;
  assign bus.cdb_src    = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  localparam int NUM_SRC  = 3;
  localparam int DATA_W   = 32;
  localparam int ROB_ID_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rdy   = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) bus ();

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] d, input logic [4:0] id);
    bus.src_valid[i]                       = 1'b1;
    bus.src_data[i*DATA_W +: DATA_W]       = d;
    bus.src_rob_id[i*ROB_ID_W +: ROB_ID_W] = id;
  endtask

  task automatic idle_src;
    bus.src_valid = '0;
  endtask

  task automatic clean;
    rdy   = 1'b1;
    idle_src();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset;
    rdy = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", bus.cdb_valid); end
    total++; if (bus.cdb_src !== 2'd0) begin bad++; $display("FAIL rst_src got=%h exp=0", bus.cdb_src); end
    total++; if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL rst_ready got=%b exp=111", bus.src_ready); end
    total++; if ({bus.cdb_data, bus.cdb_rob_id} !== '0) begin bad++; $display("FAIL rst_payload got=%h exp=0", {bus.cdb_data, bus.cdb_rob_id}); end
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_valid got=%h exp=0", bus.cdb_valid); end
    total++; if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL rst_rel_ready got=%b exp=111", bus.src_ready); end
  endtask

  task automatic test_single;
    set_src(0, 32'h0000_1234, 5'd3);
    tick();
    idle_src();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%h exp=0", bus.cdb_valid); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd3, 2'd0}) begin bad++; $display("FAIL single_bcast got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd3, 2'd0}); end
    total++; if (bus.cdb_data !== 32'h0000_1234) begin bad++; $display("FAIL single_data got=%h exp=00001234", bus.cdb_data); end
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%h exp=0", bus.cdb_valid); end
    total++; if (bus.cdb_data !== 32'h0000_1234) begin bad++; $display("FAIL single_hold got=%h exp=00001234", bus.cdb_data); end
  endtask

  task automatic test_contention;
    clean();
    set_src(0, 32'hA1, 5'd1);
    set_src(1, 32'hA2, 5'd2);
    set_src(2, 32'hA3, 5'd3);
    tick();
    idle_src();
    total++; if (bus.src_ready !== 3'b001) begin bad++; $display("FAIL cont_ready got=%b exp=001", bus.src_ready); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd1, 2'd0, 32'hA1}) begin bad++; $display("FAIL cont_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd1, 2'd0, 32'hA1}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd2, 2'd1, 32'hA2}) begin bad++; $display("FAIL cont_b2 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd2, 2'd1, 32'hA2}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd3, 2'd2, 32'hA3}) begin bad++; $display("FAIL cont_b3 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd3, 2'd2, 32'hA3}); end
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL cont_end got=%h exp=0", bus.cdb_valid); end
    // Pointer back at 0: src1 must beat src2 when both arrive together.
    set_src(1, 32'hB1, 5'd14);
    set_src(2, 32'hB2, 5'd15);
    tick();
    idle_src();
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd14, 2'd1}) begin bad++; $display("FAIL cont_ptr1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd14, 2'd1}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd15, 2'd2}) begin bad++; $display("FAIL cont_ptr2 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd15, 2'd2}); end
  endtask

  task automatic test_fairness;
    clean();
    set_src(0, 32'h1, 5'd1);
    set_src(1, 32'h2, 5'd2);
    set_src(2, 32'h3, 5'd3);
    tick();
    idle_src();
    set_src(0, 32'h4, 5'd4);
    total++; if (bus.src_ready !== 3'b001) begin bad++; $display("FAIL fair_rdy1 got=%b exp=001", bus.src_ready); end
`ifndef CDB_FIXED_PRIO_EN
    tick();
    set_src(0, 32'h5, 5'd5);
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd1, 2'd0}) begin bad++; $display("FAIL fair_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd1, 2'd0}); end
    total++; if (bus.src_ready !== 3'b010) begin bad++; $display("FAIL fair_rdy2 got=%b exp=010", bus.src_ready); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd2, 2'd1}) begin bad++; $display("FAIL fair_b2 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd2, 2'd1}); end
    total++; if (bus.src_ready !== 3'b110) begin bad++; $display("FAIL fair_rdy3 got=%b exp=110", bus.src_ready); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd3, 2'd2}) begin bad++; $display("FAIL fair_b3 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd3, 2'd2}); end
    total++; if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL fair_rdy4 got=%b exp=111", bus.src_ready); end
    tick();
    idle_src();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd4, 2'd0}) begin bad++; $display("FAIL fair_b4 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd4, 2'd0}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd5, 2'd0}) begin bad++; $display("FAIL fair_b5 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd5, 2'd0}); end
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL fair_end got=%h exp=0", bus.cdb_valid); end
`else
    tick();
    set_src(0, 32'h5, 5'd5);
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd1, 2'd0}) begin bad++; $display("FAIL fix_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd1, 2'd0}); end
    total++; if (bus.src_ready !== 3'b001) begin bad++; $display("FAIL fix_rdy got=%b exp=001", bus.src_ready); end
    tick();
    set_src(0, 32'h6, 5'd6);
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd4, 2'd0}) begin bad++; $display("FAIL fix_b2 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd4, 2'd0}); end
    tick();
    idle_src();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd5, 2'd0}) begin bad++; $display("FAIL fix_b3 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd5, 2'd0}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd6, 2'd0}) begin bad++; $display("FAIL fix_b4 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd6, 2'd0}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd2, 2'd1}) begin bad++; $display("FAIL fix_b5 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd2, 2'd1}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd3, 2'd2}) begin bad++; $display("FAIL fix_b6 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd3, 2'd2}); end
`endif
  endtask

  task automatic test_backpressure;
    clean();
    set_src(0, 32'h1111, 5'd10);
    set_src(1, 32'hAAAA, 5'd6);
    tick();
    idle_src();
    set_src(1, 32'hBEEF, 5'd7);
    total++; if (bus.src_ready !== 3'b101) begin bad++; $display("FAIL bp_ready got=%b exp=101", bus.src_ready); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd10, 2'd0}) begin bad++; $display("FAIL bp_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd10, 2'd0}); end
    total++; if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL bp_ready2 got=%b exp=111", bus.src_ready); end
    tick();
    idle_src();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd6, 2'd1, 32'hAAAA}) begin bad++; $display("FAIL bp_b2 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd6, 2'd1, 32'hAAAA}); end
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd7, 2'd1, 32'hBEEF}) begin bad++; $display("FAIL bp_b3 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd7, 2'd1, 32'hBEEF}); end
    for (int n = 0; n < 2; n++) begin
      tick();
      total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL bp_once[%0d] got=%h exp=0", n, bus.cdb_valid); end
    end
  endtask

  task automatic test_flush;
    clean();
    set_src(0, 32'hF1, 5'd11);
    set_src(1, 32'hF2, 5'd12);
    set_src(2, 32'hF3, 5'd13);
    tick();
    idle_src();
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd11, 2'd0}) begin bad++; $display("FAIL fl_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd11, 2'd0}); end
    flush = 1'b1;
    set_src(0, 32'hF4, 5'd20);
    #1;
    total++; if (bus.src_ready !== 3'b000) begin bad++; $display("FAIL fl_ready_low got=%b exp=000", bus.src_ready); end
    tick();
    flush = 1'b0;
    idle_src();
    #1;
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%h exp=0", bus.cdb_valid); end
    total++; if (bus.src_ready !== 3'b111) begin bad++; $display("FAIL fl_ready got=%b exp=111", bus.src_ready); end
    for (int n = 0; n < 4; n++) begin
      tick();
      total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL fl_quiet[%0d] got=%h id=%h exp=0", n, bus.cdb_valid, bus.cdb_rob_id); end
    end
  endtask

  task automatic test_freeze;
    clean();
    set_src(0, 32'h88, 5'd8);
    set_src(2, 32'h99, 5'd9);
    tick();
    idle_src();
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd8, 2'd0}) begin bad++; $display("FAIL frz_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd8, 2'd0}); end
    rdy = 1'b0;
    #1;
    total++; if (bus.src_ready !== 3'b000) begin bad++; $display("FAIL frz_ready got=%b exp=000", bus.src_ready); end
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd8, 2'd0, 32'h88}) begin bad++; $display("FAIL frz_hold[%0d] got=%h exp=%h", n, {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd8, 2'd0, 32'h88}); end
      total++; if (bus.src_ready !== 3'b000) begin bad++; $display("FAIL frz_rdy[%0d] got=%b exp=000", n, bus.src_ready); end
    end
    rdy = 1'b1;
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data} !== {1'b1, 5'd9, 2'd2, 32'h99}) begin bad++; $display("FAIL frz_b2 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src, bus.cdb_data}, {1'b1, 5'd9, 2'd2, 32'h99}); end
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL frz_end got=%h exp=0", bus.cdb_valid); end
  endtask

  task automatic test_async_reset;
    clean();
    set_src(1, 32'h21, 5'd21);
    tick();
    idle_src();
    tick();
    total++; if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src} !== {1'b1, 5'd21, 2'd1}) begin bad++; $display("FAIL ar_b1 got=%h exp=%h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_src}, {1'b1, 5'd21, 2'd1}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%h exp=0", bus.cdb_valid); end
    total++; if (bus.cdb_src !== 2'd0) begin bad++; $display("FAIL ar_src got=%h exp=0", bus.cdb_src); end
    tick();
    rst_n = 1'b1;
  endtask

  // Directed scenario sequence followed by the summary line.
  initial begin
    bus.src_valid  = '0;
    bus.src_data   = '0;
    bus.src_rob_id = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_flush();
    test_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common-data-bus write path into the reorder buffer between result producers: ALU = source 0, LSB = source 1, MUL/DIV = source 2.
- Each source gets a one-entry holding slot. A round-robin arbiter picks one full slot per cycle and drives a registered CDB broadcast, consumed by the ROB and the reservation stations.
- A mispredict flush from the ROB discards all in-flight results.

Parameters:
- NUM_SRC, 3, number of result sources (2..4).
- DATA_W, 32, result width.
- ROB_ID_W, 5, ROB entry id width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  ROB wrong_commit; discards all pending results.
- src_valid  in  NUM_SRC  per-source result valid.
- src_data  in  NUM_SRC*DATA_W  per-source result, source i at bits [i*DATA_W +: DATA_W].
- src_rob_id  in  NUM_SRC*ROB_ID_W  per-source destination ROB id.
- src_ready  out  NUM_SRC  slot can accept this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_data  out  DATA_W  broadcast result.
- cdb_rob_id  out  ROB_ID_W  broadcast ROB id.
- cdb_src  out  2  index of the granted source.

Behaviour:
- State per source i: slot_valid[i], slot_data[i], slot_id[i]. Global state: rr_ptr (2 bits), plus the registered cdb_* outputs.
- Reset (rst_n low, asynchronous): all slot_valid=0, rr_ptr=0, cdb_valid=0, cdb_data=0, cdb_rob_id=0, cdb_src=0.
- Grant (combinational): scan indices rr_ptr, rr_ptr+1, ... modulo NUM_SRC. The first i with slot_valid[i]=1 is granted, giving grant one-hot or zero.
- src_ready[i] = rdy & ~flush & (~slot_valid[i] | grant[i]). A slot is freed and refilled in the same cycle, so each source sustains one result per cycle when uncontended.
- Accept: on an edge with src_valid[i] & src_ready[i], slot i loads data and id, and slot_valid[i]=1.
- If src_valid[i] is high while src_ready[i] is low, the source must hold its values. The arbiter never drops an accepted result.
- Broadcast, on an edge where any grant is set:
  - cdb_valid=1; cdb_data/cdb_rob_id come from the granted slot; cdb_src=index.
  - slot_valid[granted]=0 unless refilled on the same edge.
  - rr_ptr = (index+1) mod NUM_SRC.
- No grant: cdb_valid=0 and cdb_data/id/src hold; rr_ptr holds.
- Latency: a result accepted at edge T is broadcast with cdb_valid high after edge T+1 at the earliest.
- Each cdb_valid pulse is exactly one cycle per result. The same result is never broadcast twice.
- Fairness: with all slots continuously full, each source is granted exactly once every NUM_SRC cycles. A waiting slot waits at most NUM_SRC-1 cycles.
- flush=1 at an edge (priority over accept and grant): all slot_valid=0, cdb_valid=0, rr_ptr=0. Data registers may hold.
- flush and src_valid in the same cycle: no accept, because src_ready is 0.
- rdy=0: no register changes, src_ready=0, and outputs hold their current values.
- Asynchronous reset asserted mid-broadcast clears cdb_valid immediately, without waiting for a clock edge.
- ROB id 0 is passed through unmodified; id validity is the source's responsibility.

Optional Feature:
- Macro CDB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with a full slot always wins, and rr_ptr is not implemented. The ALU is favoured for short-latency wakeup, and higher sources can starve under sustained ALU load.
- Undefined (default): round-robin exactly as in Behaviour.

Test Plan:
- Reset: hold rst_n low for 2 cycles with rdy=1 -> cdb_valid=0, cdb_src=0, src_ready=3'b111. Release rst_n -> state unchanged until the first src_valid.
- Single result: src0 data 0x00001234, id 3, accepted at edge T -> after edge T+1: cdb_valid=1, cdb_data=0x00001234, cdb_rob_id=3, cdb_src=0. After edge T+2: cdb_valid=0.
- Contention: all three sources present results at edge T (ids 1,2,3) with rr_ptr=0 -> broadcasts in cycles T+1..T+3 carry ids 1,2,3 with cdb_src 0,1,2; rr_ptr ends at 0. Under CDB_FIXED_PRIO_EN with src0 refilling every cycle -> src1 and src2 are never granted while src0 stays full.
- Backpressure: src1 slot full and src0 granted -> src_ready[1]=0. src1 holds 0xBEEF, id 7 -> it is accepted and later broadcast exactly once.
- Flush mid-operation: all slots full, flush=1 for 1 cycle -> next cycle cdb_valid=0 and src_ready=3'b111. None of the flushed ids are ever broadcast.
- Freeze: a slot is full and rdy=0 for 3 cycles -> no cdb change and src_ready=0. With rdy=1 again -> the broadcast occurs after the next edge.
